// File: rtl/uart_packet_top.sv
// Full-duplex UART packet engine: serializes 56-bit bridge packets byte by byte
// (start, 8 data LSB-first, optional parity, stop) and reassembles them on RX.
module uart_packet_top #(
  parameter int PKT_BYTES = 7,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sdata_rx,
  input  logic                   part_en_uart,
  input  logic                   part_type_uart,
  input  logic                   err_inj_en_uart,
  input  logic [1:0]             err_inj_type,
  input  logic                   par_count_clr_uart,
  input  logic [1:0]             clk_rate,
  input  logic                   loop_uart,
  input  logic                   full_to_rx,
  input  logic [8*PKT_BYTES-1:0] preq,
  input  logic [8*PKT_BYTES-1:0] pres,
  input  logic                   data_vld_tx,
  input  logic                   par_err_count_en_uart,
  input  logic                   data_sel,
  output logic                   busy,
  output logic                   err_inj_done_uart,
  output logic                   sdata_tx,
  output logic [CNT_W-1:0]       par_err_count_uart,
  output logic                   data_vld_rx,
  output logic [8*PKT_BYTES-1:0] pdata_out
);
  localparam int DW  = 8 * PKT_BYTES;
  localparam int BCW = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(PKT_BYTES - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  function automatic logic [5:0] bit_last(input logic [1:0] r);
    return 6'((32'd8 << r) - 32'd1);
  endfunction

  function automatic logic [5:0] half_last(input logic [1:0] r);
    return 6'((32'd4 << r) - 32'd1);
  endfunction

  // ---------------- TX ----------------
  state_e           tx_state_q, tx_state_d;
  logic [5:0]       tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [BCW-1:0]   tx_byte_q, tx_byte_d;
  logic [DW-1:0]    tx_word_q, tx_word_d;
  logic [1:0]       tx_rate_q, tx_rate_d;
  logic             tx_pen_q, tx_pen_d;
  logic             tx_ptype_q, tx_ptype_d;
  logic             tx_inj_q, tx_inj_d;
  logic [1:0]       tx_kind_q, tx_kind_d;
  logic             sdata_tx_q, sdata_tx_d;
  logic             tx_last, tx_inj0;
  logic [7:0]       tx_cur;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 6'd1;
    tx_bit_d   = tx_bit_q;
    tx_byte_d  = tx_byte_q;
    tx_word_d  = tx_word_q;
    tx_rate_d  = tx_rate_q;
    tx_pen_d   = tx_pen_q;
    tx_ptype_d = tx_ptype_q;
    tx_inj_d   = tx_inj_q;
    tx_kind_d  = tx_kind_q;
    tx_last    = (tx_cnt_q == bit_last(tx_rate_q));
    if (tx_last) tx_cnt_d = '0;
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        if (data_vld_tx) begin
          tx_state_d = S_START;
          tx_word_d  = data_sel ? pres : preq;
          tx_rate_d  = clk_rate;
          tx_pen_d   = part_en_uart;
          tx_ptype_d = part_type_uart;
          tx_kind_d  = err_inj_type;
          // Parity-bit injections have nothing to corrupt without parity.
          tx_inj_d   = err_inj_en_uart & (err_inj_type[1] | part_en_uart);
          tx_bit_d   = '0;
          tx_byte_d  = '0;
        end
      end
      S_START:  if (tx_last) begin tx_state_d = S_DATA; tx_bit_d = '0; end
      S_DATA: begin
        if (tx_last) begin
          tx_bit_d = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = tx_pen_q ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: if (tx_last) tx_state_d = S_STOP;
      S_STOP: begin
        if (tx_last) begin
          if (tx_byte_q == LAST_BYTE) begin
            tx_state_d = S_IDLE;
            tx_inj_d   = 1'b0;
          end else begin
            tx_state_d = S_START;
            tx_byte_d  = tx_byte_q + BCW'(1);
            tx_word_d  = {tx_word_q[DW-9:0], 8'h00};
          end
        end
      end
      default: tx_state_d = S_IDLE;
    endcase

    // Line level is registered from next-state so sdata_tx is glitch-free.
    tx_cur     = tx_word_d[DW-1 -: 8];
    tx_inj0    = tx_inj_d && (tx_byte_d == '0);
    sdata_tx_d = 1'b1;
    case (tx_state_d)
      S_START:  sdata_tx_d = 1'b0;
      S_DATA:   sdata_tx_d = tx_cur[tx_bit_d] ^ (tx_inj0 && tx_kind_d == 2'b11 && tx_bit_d == 3'd0);
      S_PARITY: sdata_tx_d = ^tx_cur ^ tx_ptype_d ^
                  (tx_inj_d && ((tx_kind_d == 2'b00 && tx_byte_d == '0) ||
                                (tx_kind_d == 2'b01 && tx_byte_d == LAST_BYTE)));
      S_STOP:   sdata_tx_d = ~(tx_inj0 && tx_kind_d == 2'b10);
      default:  sdata_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_byte_q  <= '0;
      tx_word_q  <= '0;
      tx_rate_q  <= '0;
      tx_pen_q   <= 1'b0;
      tx_ptype_q <= 1'b0;
      tx_inj_q   <= 1'b0;
      tx_kind_q  <= '0;
      sdata_tx_q <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_byte_q  <= tx_byte_d;
      tx_word_q  <= tx_word_d;
      tx_rate_q  <= tx_rate_d;
      tx_pen_q   <= tx_pen_d;
      tx_ptype_q <= tx_ptype_d;
      tx_inj_q   <= tx_inj_d;
      tx_kind_q  <= tx_kind_d;
      sdata_tx_q <= sdata_tx_d;
    end
  end

  assign busy              = (tx_state_q != S_IDLE);
  assign err_inj_done_uart = tx_inj_q;
  assign sdata_tx          = sdata_tx_q;

  // ---------------- RX ----------------
  state_e           rx_state_q, rx_state_d;
  logic             sync1_q, sync2_q, prev_q;
  logic [5:0]       rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [BCW-1:0]   rx_nbyte_q, rx_nbyte_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic [DW-1:0]    rx_pkt_q, rx_pkt_d;
  logic             rx_perr_q, rx_perr_d;
  logic             rx_bad_q, rx_bad_d;
  logic [1:0]       rx_rate_q, rx_rate_d;
  logic             rx_pen_q, rx_pen_d;
  logic             rx_ptype_q, rx_ptype_d;
  logic [DW-1:0]    pdata_q, pdata_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] perr_cnt_q, perr_cnt_d;
  logic             rx_last, rx_half, rx_inc;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 6'd1;
    rx_bit_d   = rx_bit_q;
    rx_nbyte_d = rx_nbyte_q;
    rx_sh_d    = rx_sh_q;
    rx_pkt_d   = rx_pkt_q;
    rx_perr_d  = rx_perr_q;
    rx_bad_d   = rx_bad_q;
    rx_rate_d  = rx_rate_q;
    rx_pen_d   = rx_pen_q;
    rx_ptype_d = rx_ptype_q;
    pdata_d    = pdata_q;
    vld_d      = 1'b0;
    rx_inc     = 1'b0;
    rx_last    = (rx_cnt_q == bit_last(rx_rate_q));
    rx_half    = (rx_cnt_q == half_last(rx_rate_q));
    case (rx_state_q)
      S_IDLE: begin
        if (prev_q && !sync2_q) begin
          rx_state_d = S_START;
          rx_cnt_d   = '0;
          if (rx_nbyte_q == '0) begin
            rx_rate_d  = clk_rate;
            rx_pen_d   = part_en_uart;
            rx_ptype_d = part_type_uart;
          end
        end else if (rx_nbyte_q != '0) begin
          // Bytes arrive back-to-back; a full idle bit mid-packet means the
          // packet was broken, so drop the partial and resync on the next one.
          if (rx_last) begin
            rx_nbyte_d = '0;
            rx_bad_d   = 1'b0;
            rx_cnt_d   = '0;
          end
        end else begin
          rx_cnt_d = '0;
        end
      end
      S_START: begin
        if (rx_half) begin
          rx_cnt_d = '0;
          if (!sync2_q) begin
            rx_state_d = S_DATA;
            rx_bit_d   = '0;
            rx_perr_d  = 1'b0;
          end else begin
            rx_state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (rx_last) begin
          rx_cnt_d = '0;
          rx_sh_d  = {sync2_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = rx_pen_q ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (rx_last) begin
          rx_cnt_d   = '0;
          rx_perr_d  = ^rx_sh_q ^ sync2_q ^ rx_ptype_q;
          rx_inc     = rx_perr_d & par_err_count_en_uart;
          rx_state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_last) begin
          rx_cnt_d   = '0;
          rx_state_d = S_IDLE;
          if (!sync2_q) begin
            rx_nbyte_d = '0;
            rx_bad_d   = 1'b0;
          end else begin
            rx_pkt_d = {rx_pkt_q[DW-9:0], rx_sh_q};
            if (rx_nbyte_q == LAST_BYTE) begin
              rx_nbyte_d = '0;
              rx_bad_d   = 1'b0;
              if (!rx_bad_q && !rx_perr_q && !full_to_rx) begin
                pdata_d = rx_pkt_d;
                vld_d   = 1'b1;
              end
            end else begin
              rx_nbyte_d = rx_nbyte_q + BCW'(1);
              rx_bad_d   = rx_bad_q | rx_perr_q;
            end
          end
        end
      end
      default: rx_state_d = S_IDLE;
    endcase

    perr_cnt_d = perr_cnt_q;
    if (par_count_clr_uart)                  perr_cnt_d = '0;
    else if (rx_inc && perr_cnt_q != '1)     perr_cnt_d = perr_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_nbyte_q <= '0;
      rx_sh_q    <= '0;
      rx_pkt_q   <= '0;
      rx_perr_q  <= 1'b0;
      rx_bad_q   <= 1'b0;
      rx_rate_q  <= '0;
      rx_pen_q   <= 1'b0;
      rx_ptype_q <= 1'b0;
      pdata_q    <= '0;
      vld_q      <= 1'b0;
      perr_cnt_q <= '0;
    end else begin
      sync1_q    <= loop_uart ? sdata_tx_q : sdata_rx;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_nbyte_q <= rx_nbyte_d;
      rx_sh_q    <= rx_sh_d;
      rx_pkt_q   <= rx_pkt_d;
      rx_perr_q  <= rx_perr_d;
      rx_bad_q   <= rx_bad_d;
      rx_rate_q  <= rx_rate_d;
      rx_pen_q   <= rx_pen_d;
      rx_ptype_q <= rx_ptype_d;
      pdata_q    <= pdata_d;
      vld_q      <= vld_d;
      perr_cnt_q <= perr_cnt_d;
    end
  end

  assign pdata_out          = pdata_q;
  assign data_vld_rx        = vld_q;
  assign par_err_count_uart = perr_cnt_q;

endmodule

// File: tb/tb_uart_packet_top.sv
// Directed loopback bench for uart_packet_top: framing timing, injection,
// parity counter, full-drop and async reset behaviour.
module tb_uart_packet_top;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sdata_rx = 1'b1;
  logic        part_en_uart = 1'b0, part_type_uart = 1'b0;
  logic        err_inj_en_uart = 1'b0;
  logic [1:0]  err_inj_type = 2'b00;
  logic        par_count_clr_uart = 1'b0;
  logic [1:0]  clk_rate = 2'b00;
  logic        loop_uart = 1'b1, full_to_rx = 1'b0;
  logic [55:0] preq = '0, pres = '0;
  logic        data_vld_tx = 1'b0, par_err_count_en_uart = 1'b0, data_sel = 1'b0;
  logic        busy, err_inj_done_uart, sdata_tx, data_vld_rx;
  logic [15:0] par_err_count_uart;
  logic [55:0] pdata_out;

  uart_packet_top dut (
    .clk(clk), .rst(rst), .sdata_rx(sdata_rx), .part_en_uart(part_en_uart),
    .part_type_uart(part_type_uart), .err_inj_en_uart(err_inj_en_uart),
    .err_inj_type(err_inj_type), .par_count_clr_uart(par_count_clr_uart),
    .clk_rate(clk_rate), .loop_uart(loop_uart), .full_to_rx(full_to_rx),
    .preq(preq), .pres(pres), .data_vld_tx(data_vld_tx),
    .par_err_count_en_uart(par_err_count_en_uart), .data_sel(data_sel),
    .busy(busy), .err_inj_done_uart(err_inj_done_uart), .sdata_tx(sdata_tx),
    .par_err_count_uart(par_err_count_uart), .data_vld_rx(data_vld_rx),
    .pdata_out(pdata_out)
  );

  always #5 clk = ~clk;

  int checks = 0, passes = 0, vld_cnt = 0;
  always @(negedge clk) if (data_vld_rx === 1'b1) vld_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Sends one packet and waits for busy to fall plus RX settle time.
  task automatic send(input logic sel, input logic [1:0] rate, input logic pen, input logic ptype,
                      input logic inj, input logic [1:0] kind, input logic [55:0] word,
                      input bit poke, output int nbusy, output int nlow,
                      output logic inj_seen, output logic inj_after);
    bit low_done;
    @(negedge clk);
    data_sel = sel; clk_rate = rate; part_en_uart = pen; part_type_uart = ptype;
    err_inj_en_uart = inj; err_inj_type = kind;
    if (sel) pres = word; else preq = word;
    data_vld_tx = 1'b1;
    @(negedge clk);
    data_vld_tx = 1'b0; err_inj_en_uart = 1'b0;
    inj_seen = err_inj_done_uart;
    nbusy = 0; nlow = 0; low_done = 0;
    while (busy === 1'b1 && nbusy < 20000) begin
      nbusy++;
      if (!low_done) begin
        if (sdata_tx === 1'b0) nlow++;
        else if (nlow > 0) low_done = 1;
      end
      if (poke) begin
        data_vld_tx = (nbusy == 50 || nbusy == 300);
        data_sel    = ~sel;
      end
      @(negedge clk);
    end
    data_vld_tx = 1'b0;
    data_sel = sel;
    inj_after = err_inj_done_uart;
    repeat (250) @(negedge clk);
  endtask

  int nb, nl, v0;
  logic is, ia;

  initial begin
    #22;
    check("rst_sdata_tx", sdata_tx, 1);
    check("rst_busy", busy, 0);
    check("rst_inj_done", err_inj_done_uart, 0);
    check("rst_vld", data_vld_rx, 0);
    check("rst_pdata", pdata_out, 0);
    check("rst_count", par_err_count_uart, 0);
    @(negedge clk); rst = 1'b1;
    repeat (5) @(negedge clk);

    // Even parity, 32 clocks/bit, preq
    v0 = vld_cnt;
    send(0, 2'b10, 1, 0, 0, 2'b00, 56'h03FFFF00000000, 0, nb, nl, is, ia);
    check("t1_busy_len", nb, 2464);
    check("t1_start_low", nl, 32);
    check("t1_vld_cnt", vld_cnt - v0, 1);
    check("t1_pdata", pdata_out, 56'h03FFFF00000000);
    check("t1_count", par_err_count_uart, 0);

    // Odd parity, 8 clocks/bit, pres
    v0 = vld_cnt;
    send(1, 2'b00, 1, 1, 0, 2'b00, 56'h040000FFFFFFFF, 0, nb, nl, is, ia);
    check("t2_busy_len", nb, 616);
    check("t2_vld_cnt", vld_cnt - v0, 1);
    check("t2_pdata", pdata_out, 56'h040000FFFFFFFF);

    // Inject inverted parity on cmd byte
    par_err_count_en_uart = 1'b1;
    v0 = vld_cnt;
    send(0, 2'b00, 1, 0, 1, 2'b00, 56'h02112233445566, 0, nb, nl, is, ia);
    check("t3_inj_done_during", is, 1);
    check("t3_inj_done_after", ia, 0);
    check("t3_vld_cnt", vld_cnt - v0, 0);
    check("t3_count", par_err_count_uart, 1);
    check("t3_pdata_held", pdata_out, 56'h040000FFFFFFFF);
    @(negedge clk); par_count_clr_uart = 1'b1;
    @(negedge clk); par_count_clr_uart = 1'b0;
    check("t3_count_clr", par_err_count_uart, 0);

    // Stop bit of byte 0 low, then a clean packet
    v0 = vld_cnt;
    send(0, 2'b00, 1, 0, 1, 2'b10, 56'h02000000000000, 0, nb, nl, is, ia);
    check("t4_inj_done", is, 1);
    check("t4_vld_cnt", vld_cnt - v0, 0);
    check("t4_count", par_err_count_uart, 0);
    v0 = vld_cnt;
    send(0, 2'b00, 1, 0, 0, 2'b00, 56'h03123456789ABC, 0, nb, nl, is, ia);
    check("t4_clean_vld", vld_cnt - v0, 1);
    check("t4_clean_pdata", pdata_out, 56'h03123456789ABC);

    // Downstream full drops the packet
    full_to_rx = 1'b1;
    v0 = vld_cnt;
    send(0, 2'b00, 1, 0, 0, 2'b00, 56'h04AAAAAAAAAAAA, 0, nb, nl, is, ia);
    check("t5_full_vld", vld_cnt - v0, 0);
    check("t5_full_pdata", pdata_out, 56'h03123456789ABC);
    full_to_rx = 1'b0;
    v0 = vld_cnt;
    send(0, 2'b00, 1, 0, 0, 2'b00, 56'h04AAAAAAAAAAAA, 0, nb, nl, is, ia);
    check("t5_nofull_vld", vld_cnt - v0, 1);
    check("t5_nofull_pdata", pdata_out, 56'h04AAAAAAAAAAAA);

    // data_vld_tx pulses while busy are ignored; parity off -> 10 bits/byte
    pres = 56'h04DEADBEEF0001;
    v0 = vld_cnt;
    send(0, 2'b00, 0, 0, 0, 2'b00, 56'h02A5A5A5A5A5A5, 1, nb, nl, is, ia);
    check("t6_busy_len", nb, 560);
    check("t6_vld_cnt", vld_cnt - v0, 1);
    check("t6_pdata", pdata_out, 56'h02A5A5A5A5A5A5);

    // Async reset mid-packet
    @(negedge clk);
    data_sel = 0; clk_rate = 2'b10; part_en_uart = 1; preq = 56'h03C3C3C3C3C3C3;
    data_vld_tx = 1'b1;
    @(negedge clk); data_vld_tx = 1'b0;
    repeat (100) @(negedge clk);
    check("t7_busy_before", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("t7_rst_sdata_tx", sdata_tx, 1);
    check("t7_rst_busy", busy, 0);
    check("t7_rst_pdata", pdata_out, 0);
    @(negedge clk); rst = 1'b1;
    v0 = vld_cnt;
    repeat (400) @(negedge clk);
    check("t7_idle_busy", busy, 0);
    check("t7_no_vld", vld_cnt - v0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/uart_packet_top.md
Name: uart_packet_top

Overview:
- Full-duplex UART packet engine carrying 56-bit (7-byte) bridge packets (request/response) between a parallel side and a serial line.
- TX serializes a selected 56-bit word: per byte, start bit, 8 data bits LSB-first, optional parity bit, stop bit. RX performs the inverse.
- Also provides programmable bit rate, internal loopback, one-shot error injection and a parity-error counter.
- Sits between the APB bridge logic and the serial pins.

Parameters:
- PKT_BYTES, 7, bytes per packet (data width = 8*PKT_BYTES = 56).
- CNT_W, 16, parity-error counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- sdata_rx  in  1  serial input, idle high.
- part_en_uart  in  1  parity enable.
- part_type_uart  in  1  parity type: 0 even, 1 odd.
- err_inj_en_uart  in  1  arms one-shot error injection on the next TX packet.
- err_inj_type  in  2  injection kind (see Behaviour).
- par_count_clr_uart  in  1  synchronous clear of the parity-error counter.
- clk_rate  in  2  clocks per bit: 00=8, 01=16, 10=32, 11=64.
- loop_uart  in  1  1: RX input is internal sdata_tx; sdata_rx is ignored.
- full_to_rx  in  1  downstream full; a packet completing while this is high is dropped.
- preq  in  56  request word to transmit.
- pres  in  56  response word to transmit.
- data_vld_tx  in  1  TX start request.
- par_err_count_en_uart  in  1  parity-error counting enable.
- data_sel  in  1  TX source select: 0 preq, 1 pres.
- busy  out  1  TX packet in progress.
- err_inj_done_uart  out  1  high while an injected packet is being transmitted.
- sdata_tx  out  1  serial output, idle high.
- par_err_count_uart  out  16  saturating count of RX parity errors.
- data_vld_rx  out  1  one-cycle pulse when pdata_out is valid.
- pdata_out  out  56  received packet.

Behaviour:
- Reset (rst=0, async) values:
  - sdata_tx=1; busy=0; err_inj_done_uart=0; data_vld_rx=0; pdata_out=0; par_err_count_uart=0.
  - All FSMs go to IDLE.
- Bit timer: N = 8<<clk_rate clocks per bit. clk_rate, part_en_uart and part_type_uart are sampled at packet start and held for the whole packet.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - In IDLE, data_vld_tx=1 latches (data_sel ? pres : preq) and sets busy the next cycle. START begins on that same cycle.
  - data_vld_tx is ignored while busy.
- Byte order: bits [55:48] are sent first, down to [7:0]. The cmd byte is 0x02/0x03/0x04 in [55:48].
- Framing rules:
  - PARITY state is skipped when parity is disabled.
  - Parity = XOR of the data bits, inverted for odd parity.
  - Successive bytes follow back-to-back: the stop bit is followed directly by the next start bit.
  - busy drops in the cycle after the last stop bit completes.
- Error injection: err_inj_en_uart is sampled at packet acceptance. If set, err_inj_done_uart=1 for the whole packet, falling with busy. Kinds:
  - 00: invert the parity bit of byte 0 (cmd).
  - 01: invert the parity bit of byte 6.
  - 10: drive stop bit of byte 0 low.
  - 11: invert data bit 0 of byte 0, with parity computed on the uninverted byte.
  - Kinds 00/01 with parity disabled: no injection, and err_inj_done_uart stays 0.
- RX input path:
  - Input = loop_uart ? sdata_tx : sdata_rx, passed through a 2-FF synchronizer.
  - Start is detected on a falling edge in IDLE and confirmed low at N/2. Each later bit is sampled at its midpoint (every N clocks).
- RX packet assembly:
  - Bytes are assembled MSB-byte-first into a 56-bit shift register.
  - After the 7th good byte: pdata_out is updated and data_vld_rx pulses 1 cycle, unless full_to_rx=1, in which case the packet is dropped and pdata_out is held.
- RX error handling:
  - Stop bit = 0 (framing error): the packet is discarded, the byte counter resets to 0, and RX returns to IDLE.
  - Parity mismatch (parity enabled): the byte is still received, but the whole packet is discarded at completion.
- Counter:
  - Increments by 1 per RX byte with a parity mismatch when part_en_uart & par_err_count_en_uart.
  - Saturates at 0xFFFF.
  - par_count_clr_uart has priority over an increment in the same cycle.
- Loopback with injection: RX must observe the injected error exactly as an external receiver would.

Test Plan:
- Reset, loop_uart=1, parity even, clk_rate=10, data_sel=0, preq=0x03FFFF00000000, pulse data_vld_tx 1 cycle:
  - busy=1 for 7*11*32=2464 clocks.
  - sdata_tx low 32 clocks for the first start bit.
  - data_vld_rx pulses once with pdata_out=0x03FFFF00000000.
  - counter stays 0.
- data_sel=1, pres=0x040000FFFFFFFF, odd parity, clk_rate=00: busy 7*11*8=616 clocks; pdata_out=0x040000FFFFFFFF.
- err_inj_en_uart=1, type 00, loopback:
  - err_inj_done_uart=1 during the packet.
  - par_err_count_uart=1 afterwards; no data_vld_rx.
  - Assert par_count_clr_uart -> count 0.
- Type 10 injection: framing error; no data_vld_rx; counter unchanged. The next clean packet is received correctly.
- full_to_rx=1 during a loopback packet: no data_vld_rx and pdata_out unchanged. Repeat with full_to_rx=0: pulse occurs.
- Async reset mid-packet: sdata_tx=1 and busy=0 immediately. data_vld_tx pulses while busy are ignored; only one packet is sent.
